// File: rtl/match_swap_ctrl.sv
// match_swap_ctrl: remaps initiator-port match bits through a table of swap entries.
// New entries are staged in a shadow table. A commit first drains the outstanding
// transactions, then copies the shadow table into the active table in one step.
module match_swap_ctrl #(
   parameter int unsigned N_INIT_PORT = 8,
   parameter int unsigned N_REGION    = 3,
   parameter int unsigned LOG_N_INIT  = 3,
   parameter int unsigned N_ENTRY     = 4,
   parameter int unsigned CNT_W       = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   cfg_valid,
   output logic                                   cfg_ready,
   input  logic [((N_ENTRY > 1) ? $clog2(N_ENTRY) : 1)-1:0] cfg_idx,
   input  logic                                   cfg_en,
   input  logic [LOG_N_INIT-1:0]                  cfg_source,
   input  logic [LOG_N_INIT-1:0]                  cfg_target,
   input  logic                                   commit_req,
   output logic                                   commit_done,
   output logic                                   hold_o,
   input  logic                                   txn_start,
   input  logic                                   txn_end,
   output logic                                   err_o,
   input  logic [N_REGION-1:0][N_INIT_PORT-1:0]   match_region_int_i,
   output logic [N_REGION-1:0][N_INIT_PORT-1:0]   match_region_int_o
);

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   typedef struct packed {
      logic                  en;
      logic [LOG_N_INIT-1:0] source;
      logic [LOG_N_INIT-1:0] target;
   } entry_t;

   typedef enum logic [1:0] {StIdle, StDrain, StCommit} state_e;

   state_e                               state_q, state_d;
   entry_t                               shadow_q [N_ENTRY];
   entry_t                               active_q [N_ENTRY];
   logic [CNT_W-1:0]                     cnt_q, cnt_d;
   logic                                 err_q, err_d;
   logic [N_REGION-1:0][N_INIT_PORT-1:0] remap;
   logic [N_REGION-1:0][N_INIT_PORT-1:0] match_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; commit_req is only looked at in IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (commit_req) state_d = StDrain;
         StDrain:  if (cnt_q == '0 && !txn_start) state_d = StCommit;
         StCommit: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      cfg_ready   = (state_q == StIdle);
      hold_o      = (state_q != StIdle);
      commit_done = (state_q == StCommit);
   end

   // Outstanding-transaction counter; saturates at both ends and flags the attempt
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (txn_start && !txn_end) begin
         if (cnt_q == CntMax) err_d = 1'b1;
         else                 cnt_d = cnt_q + 1'b1;
      end else if (txn_end && !txn_start) begin
         if (cnt_q == '0) err_d = 1'b1;
         else             cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter and sticky error register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;

   // Shadow table writes (only accepted in IDLE, so shadow is frozen during a commit)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_ENTRY; k++) shadow_q[k] <= '0;
      end else if (cfg_valid && cfg_ready && (32'(cfg_idx) < N_ENTRY)) begin
         shadow_q[cfg_idx] <= '{en: cfg_en, source: cfg_source, target: cfg_target};
      end
   end

   // Active table: whole-table copy on the COMMIT edge, cleared by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_ENTRY; k++) active_q[k] <= '0;
      end else if (state_q == StCommit) begin
         for (int k = 0; k < N_ENTRY; k++) active_q[k] <= shadow_q[k];
      end
   end

   // Apply active entries in ascending order, each on the previous result
   always_comb begin
      remap = match_region_int_i;
      for (int k = 0; k < N_ENTRY; k++) begin
         if (active_q[k].en && (active_q[k].source != active_q[k].target) &&
             (32'(active_q[k].source) < N_INIT_PORT) &&
             (32'(active_q[k].target) < N_INIT_PORT)) begin
            for (int j = 0; j < N_REGION; j++) begin
               remap[j][active_q[k].target] = remap[j][active_q[k].target] |
                                              remap[j][active_q[k].source];
               remap[j][active_q[k].source] = 1'b0;
            end
         end
      end
   end

   // Registered remapped match vector
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         match_q <= '0;
      end else begin
         match_q <= remap;
      end
   end

   assign match_region_int_o = match_q;

endmodule

// File: tb/tb_match_swap_ctrl.sv
// Directed testbench for match_swap_ctrl: passthrough, swaps, chaining, drain, errors, reset.
module tb_match_swap_ctrl;

   localparam int NP = 8;
   localparam int NR = 3;
   localparam int LG = 3;
   localparam int NE = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Main DUT signals
   logic              cfg_valid = 0, cfg_en = 0, commit_req = 0, txn_start = 0, txn_end = 0;
   logic [1:0]        cfg_idx = '0;
   logic [LG-1:0]     cfg_source = '0, cfg_target = '0;
   logic              cfg_ready, commit_done, hold_o, err_o;
   logic [NR-1:0][NP-1:0] min = '0;
   logic [NR-1:0][NP-1:0] mout;
   logic [NR-1:0][NP-1:0] exp_v;

   // Narrow-counter DUT signals
   logic              d2_commit = 0, d2_start = 0, d2_end = 0;
   logic              d2_ready, d2_done, d2_hold, d2_err;
   logic [NR-1:0][NP-1:0] d2_out;

   int checks = 0;
   int errors = 0;

   match_swap_ctrl #(.N_INIT_PORT(NP), .N_REGION(NR), .LOG_N_INIT(LG), .N_ENTRY(NE), .CNT_W(4))
   u_dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
      .cfg_en(cfg_en), .cfg_source(cfg_source), .cfg_target(cfg_target),
      .commit_req(commit_req), .commit_done(commit_done), .hold_o(hold_o),
      .txn_start(txn_start), .txn_end(txn_end), .err_o(err_o),
      .match_region_int_i(min), .match_region_int_o(mout)
   );

   match_swap_ctrl #(.N_INIT_PORT(NP), .N_REGION(NR), .LOG_N_INIT(LG), .N_ENTRY(NE), .CNT_W(2))
   u_dut2 (
      .clk(clk), .rst(rst), .cfg_valid(1'b0), .cfg_ready(d2_ready), .cfg_idx(2'd0),
      .cfg_en(1'b0), .cfg_source(3'd0), .cfg_target(3'd0),
      .commit_req(d2_commit), .commit_done(d2_done), .hold_o(d2_hold),
      .txn_start(d2_start), .txn_end(d2_end), .err_o(d2_err),
      .match_region_int_i(min), .match_region_int_o(d2_out)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_in(input logic [7:0] r2, input logic [7:0] r1, input logic [7:0] r0);
      min = {r2, r1, r0};
   endtask

   task automatic cfg_write(input logic [1:0] idx, input logic en,
                            input logic [2:0] src, input logic [2:0] tgt);
      cfg_valid = 1'b1; cfg_idx = idx; cfg_en = en; cfg_source = src; cfg_target = tgt;
      tick();
      cfg_valid = 1'b0;
   endtask

   // Stimulus only: commit with no outstanding transactions, returns in IDLE
   task automatic do_commit();
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      tick();
      checks++; if (hold_o !== 1'b0) begin errors++; $display("FAIL reset_hold got %b want 0", hold_o); end
      checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", commit_done); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_o); end
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cfg_ready); end
      checks++; if (mout !== '0) begin errors++; $display("FAIL reset_out got %h want 0", mout); end
      rst = 1'b0;
   endtask

   task automatic test_passthrough();
      set_in(8'h00, 8'hC3, 8'h5A);
      tick();
      exp_v = {8'h00, 8'hC3, 8'h5A};
      checks++; if (mout !== exp_v) begin errors++; $display("FAIL pass_a got %h want %h", mout, exp_v); end
      set_in(8'h80, 8'h01, 8'hFF);
      tick();
      exp_v = {8'h80, 8'h01, 8'hFF};
      checks++; if (mout !== exp_v) begin errors++; $display("FAIL pass_b got %h want %h", mout, exp_v); end
      checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL pass_done got %b want 0", commit_done); end
   endtask

   task automatic test_single_swap();
      cfg_write(2'd0, 1'b1, 3'd1, 3'd4);
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
      checks++; if (hold_o !== 1'b1) begin errors++; $display("FAIL swap_hold got %b want 1", hold_o); end
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL swap_ready got %b want 0", cfg_ready); end
      checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL swap_early got %b want 0", commit_done); end
      tick();
      checks++; if (commit_done !== 1'b1) begin errors++; $display("FAIL swap_done got %b want 1", commit_done); end
      checks++; if (hold_o !== 1'b1) begin errors++; $display("FAIL swap_hold2 got %b want 1", hold_o); end
      tick();
      checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL swap_pulse got %b want 0", commit_done); end
      checks++; if (hold_o !== 1'b0) begin errors++; $display("FAIL swap_release got %b want 0", hold_o); end
      set_in(8'h81, 8'h12, 8'h02);
      tick();
      exp_v = {8'h81, 8'h10, 8'h10};
      checks++; if (mout !== exp_v) begin errors++; $display("FAIL swap_out got %h want %h", mout, exp_v); end
   endtask

   task automatic test_chained();
      cfg_write(2'd0, 1'b1, 3'd1, 3'd2);
      cfg_write(2'd1, 1'b1, 3'd2, 3'd3);
      do_commit();
      set_in(8'h01, 8'h06, 8'h02);
      tick();
      exp_v = {8'h01, 8'h08, 8'h08};
      checks++; if (mout !== exp_v) begin errors++; $display("FAIL chain_out got %h want %h", mout, exp_v); end
      cfg_write(2'd1, 1'b0, 3'd2, 3'd3);
      cfg_write(2'd2, 1'b1, 3'd5, 3'd5);
      do_commit();
      set_in(8'h0C, 8'h20, 8'h02);
      tick();
      exp_v = {8'h0C, 8'h20, 8'h04};
      checks++; if (mout !== exp_v) begin errors++; $display("FAIL chain_dis got %h want %h", mout, exp_v); end
   endtask

   task automatic test_drain();
      txn_start = 1'b1;
      repeat (3) tick();
      txn_start = 1'b0;
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
      checks++; if (hold_o !== 1'b1) begin errors++; $display("FAIL drain_hold got %b want 1", hold_o); end
      txn_start = 1'b1;
      tick();
      txn_start = 1'b0;
      tick();
      tick();
      checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL drain_wait got %b want 0", commit_done); end
      txn_end = 1'b1;
      repeat (3) tick();
      txn_start = 1'b1;
      tick();
      txn_start = 1'b0;
      tick();
      txn_end = 1'b0;
      checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL drain_zero got %b want 0", commit_done); end
      // counter is zero but a new start arrives together with an end: stay in DRAIN
      txn_start = 1'b1;
      txn_end = 1'b1;
      tick();
      txn_start = 1'b0;
      txn_end = 1'b0;
      checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL drain_start got %b want 0", commit_done); end
      checks++; if (hold_o !== 1'b1) begin errors++; $display("FAIL drain_hold2 got %b want 1", hold_o); end
      tick();
      checks++; if (commit_done !== 1'b1) begin errors++; $display("FAIL drain_done got %b want 1", commit_done); end
      tick();
      checks++; if (hold_o !== 1'b0) begin errors++; $display("FAIL drain_end got %b want 0", hold_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL drain_err got %b want 0", err_o); end
   endtask

   task automatic test_errors();
      txn_end = 1'b1;
      tick();
      txn_end = 1'b0;
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL under_err got %b want 1", err_o); end
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
      tick();
      checks++; if (commit_done !== 1'b1) begin errors++; $display("FAIL under_cnt got %b want 1", commit_done); end
      tick();
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err_o); end
      d2_start = 1'b1;
      repeat (3) tick();
      checks++; if (d2_err !== 1'b0) begin errors++; $display("FAIL over_early got %b want 0", d2_err); end
      tick();
      d2_start = 1'b0;
      checks++; if (d2_err !== 1'b1) begin errors++; $display("FAIL over_err got %b want 1", d2_err); end
      d2_commit = 1'b1;
      tick();
      d2_commit = 1'b0;
      d2_end = 1'b1;
      tick();
      tick();
      checks++; if (d2_done !== 1'b0) begin errors++; $display("FAIL over_cnt2 got %b want 0", d2_done); end
      tick();
      d2_end = 1'b0;
      checks++; if (d2_done !== 1'b0) begin errors++; $display("FAIL over_cnt1 got %b want 0", d2_done); end
      tick();
      checks++; if (d2_done !== 1'b1) begin errors++; $display("FAIL over_done got %b want 1", d2_done); end
      tick();
   endtask

   task automatic test_reset_drain();
      txn_start = 1'b1;
      tick();
      txn_start = 1'b0;
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
      checks++; if (hold_o !== 1'b1) begin errors++; $display("FAIL rd_hold got %b want 1", hold_o); end
      #1 rst = 1'b1;
      #1;
      checks++; if (hold_o !== 1'b0) begin errors++; $display("FAIL rd_hold0 got %b want 0", hold_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", err_o); end
      checks++; if (mout !== '0) begin errors++; $display("FAIL rd_out0 got %h want 0", mout); end
      tick();
      set_in(8'h40, 8'h10, 8'h02);
      rst = 1'b0;
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rd_ready got %b want 1", cfg_ready); end
      tick();
      exp_v = {8'h40, 8'h10, 8'h02};
      checks++; if (mout !== exp_v) begin errors++; $display("FAIL rd_pass got %h want %h", mout, exp_v); end
      do_commit();
      tick();
      checks++; if (mout !== exp_v) begin errors++; $display("FAIL rd_shadow got %h want %h", mout, exp_v); end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_single_swap();
      test_chained();
      test_drain();
      test_errors();
      test_reset_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
